// File: rtl/datapath_pkg.sv
// Shared constants and types for the single-bus datapath: spec_in/spec_out bit
// positions, memory handshake states and register reset values.
package datapath_pkg;

  localparam int unsigned SPEC_IN_W = 9;
  localparam int unsigned SPEC_IN_HI   = 0;
  localparam int unsigned SPEC_IN_LO   = 1;
  localparam int unsigned SPEC_IN_Z    = 2;
  localparam int unsigned SPEC_IN_PC   = 3;
  localparam int unsigned SPEC_IN_IR   = 4;
  localparam int unsigned SPEC_IN_MAR  = 5;
  localparam int unsigned SPEC_IN_MDR  = 6;
  localparam int unsigned SPEC_IN_Y    = 7;
  localparam int unsigned SPEC_IN_OUTP = 8;

  localparam int unsigned SPEC_OUT_W = 8;
  localparam int unsigned SPEC_OUT_HI  = 0;
  localparam int unsigned SPEC_OUT_LO  = 1;
  localparam int unsigned SPEC_OUT_ZHI = 2;
  localparam int unsigned SPEC_OUT_ZLO = 3;
  localparam int unsigned SPEC_OUT_PC  = 4;
  localparam int unsigned SPEC_OUT_MDR = 5;
  localparam int unsigned SPEC_OUT_IMM = 6;
  localparam int unsigned SPEC_OUT_INP = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } mem_state_t;

  // Wide zero, narrowed with a width cast to whatever register width is in use.
  localparam int unsigned REG_RST_MAX_W = 128;
  localparam logic [REG_RST_MAX_W-1:0] REG_RST_VAL = '0;

endpackage

// File: rtl/mem_handshake_fsm.sv
// Memory req/ack handshake: tracks one outstanding read or write, holds the
// address and write data stable for the whole transaction.
module mem_handshake_fsm
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  logic              mem_ack_i,
  input  logic [ADDR_W-1:0] mar_i,
  input  logic [DATA_W-1:0] mdr_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic              mem_busy_o,
  output logic              mem_done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mdr_ld_c,
  output logic              mdr_bus_blk_c
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // State and transaction latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= ADDR_W'(REG_RST_VAL);
      wdata_q <= DATA_W'(REG_RST_VAL);
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state; new requests are only looked at in IDLE, read has priority
  always_comb begin : next_state
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_rd_i) begin
          state_d = RD_WAIT;
          addr_d  = mar_i;
          wdata_d = mdr_i;
        end else if (mem_wr_i) begin
          state_d = WR_WAIT;
          addr_d  = mar_i;
          wdata_d = mdr_i;
        end
      end
      RD_WAIT: if (mem_ack_i) state_d = DONE;
      WR_WAIT: if (mem_ack_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs plus the read-data capture strobe
  always_comb begin : outputs
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_done_o    = 1'b0;
    mem_busy_o    = (state_q != IDLE);
    mdr_ld_c      = 1'b0;
    mdr_bus_blk_c = 1'b0;
    case (state_q)
      RD_WAIT: begin
        mem_req_o     = 1'b1;
        mdr_bus_blk_c = 1'b1;
        mdr_ld_c      = mem_ack_i;
      end
      WR_WAIT: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
      end
      DONE:    mem_done_o = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_bus_datapath.sv
// Single-bus CPU datapath: GPRs, HI/LO, Y, Z, PC, IR, MAR, MDR and outport on one
// OR-bus, with a req/ack memory port. Define DATAPATH_BUS_ERR_EN for bus_err.
module mem_bus_datapath
  import datapath_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_GPR  = 16,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned PC_RESET = 0,
  parameter int unsigned PC_INC   = 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NUM_GPR-1:0]    gpr_in,
  input  logic [NUM_GPR-1:0]    gpr_out,
  input  logic                  ba_out,
  input  logic [SPEC_IN_W-1:0]  spec_in,
  input  logic [SPEC_OUT_W-1:0] spec_out,
  input  logic                  inc_pc,
  input  logic [DATA_W-1:0]     imm_in,
  input  logic [DATA_W-1:0]     inport_data,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  input  logic [DATA_W-1:0]     alu_lo,
  input  logic [DATA_W-1:0]     alu_hi,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  mem_busy,
  output logic                  mem_done,
  output logic [DATA_W-1:0]     bus,
  output logic [DATA_W-1:0]     ir,
  output logic [DATA_W-1:0]     outport
`ifdef DATAPATH_BUS_ERR_EN
  ,
  output logic                  bus_err
`endif
);

  localparam logic [DATA_W-1:0] REG_RST = DATA_W'(REG_RST_VAL);
  localparam logic [DATA_W-1:0] PC_RST  = DATA_W'(PC_RESET);

  logic [DATA_W-1:0]  gpr_q [NUM_GPR];
  logic [DATA_W-1:0]  gpr_d [NUM_GPR];
  logic [NUM_GPR-1:0] gpr_drv;
  logic [DATA_W-1:0]  hi_q, hi_d, lo_q, lo_d, zhi_q, zhi_d, zlo_q, zlo_d;
  logic [DATA_W-1:0]  pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [DATA_W-1:0]  y_q, y_d, outp_q, outp_d;
  // Only the address bits of MAR are ever observable, so only those are stored.
  logic [ADDR_W-1:0]  mar_q, mar_d;
  logic [DATA_W-1:0]  bus_c;
  logic               mdr_ld_c, mdr_bus_blk_c;

  assign gpr_drv = gpr_out & ~{{(NUM_GPR-1){1'b0}}, ba_out};

  // Wired-OR bus; R0 reads as zero when ba_out is set
  always_comb begin : bus_or
    bus_c = '0;
    for (int i = 0; i < NUM_GPR; i++) begin
      if (gpr_drv[i]) bus_c = bus_c | gpr_q[i];
    end
    if (spec_out[SPEC_OUT_HI])  bus_c = bus_c | hi_q;
    if (spec_out[SPEC_OUT_LO])  bus_c = bus_c | lo_q;
    if (spec_out[SPEC_OUT_ZHI]) bus_c = bus_c | zhi_q;
    if (spec_out[SPEC_OUT_ZLO]) bus_c = bus_c | zlo_q;
    if (spec_out[SPEC_OUT_PC])  bus_c = bus_c | pc_q;
    if (spec_out[SPEC_OUT_MDR]) bus_c = bus_c | mdr_q;
    if (spec_out[SPEC_OUT_IMM]) bus_c = bus_c | imm_in;
    if (spec_out[SPEC_OUT_INP]) bus_c = bus_c | inport_data;
  end

  always_comb begin : reg_next
    for (int i = 0; i < NUM_GPR; i++) begin
      gpr_d[i] = gpr_in[i] ? bus_c : gpr_q[i];
    end
    hi_d   = spec_in[SPEC_IN_HI]   ? bus_c  : hi_q;
    lo_d   = spec_in[SPEC_IN_LO]   ? bus_c  : lo_q;
    zhi_d  = spec_in[SPEC_IN_Z]    ? alu_hi : zhi_q;
    zlo_d  = spec_in[SPEC_IN_Z]    ? alu_lo : zlo_q;
    ir_d   = spec_in[SPEC_IN_IR]   ? bus_c  : ir_q;
    mar_d  = spec_in[SPEC_IN_MAR]  ? bus_c[ADDR_W-1:0] : mar_q;
    y_d    = spec_in[SPEC_IN_Y]    ? bus_c  : y_q;
    outp_d = spec_in[SPEC_IN_OUTP] ? bus_c  : outp_q;
    pc_d   = pc_q;
    if (spec_in[SPEC_IN_PC]) pc_d = bus_c;
    else if (inc_pc)         pc_d = pc_q + DATA_W'(PC_INC);
    // A pending read owns MDR: bus loads are dropped until the ack delivers data
    mdr_d = mdr_q;
    if (mdr_ld_c)                                   mdr_d = mem_rdata;
    else if (spec_in[SPEC_IN_MDR] && !mdr_bus_blk_c) mdr_d = bus_c;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      gpr_q  <= '{default: REG_RST};
      hi_q   <= REG_RST;
      lo_q   <= REG_RST;
      zhi_q  <= REG_RST;
      zlo_q  <= REG_RST;
      pc_q   <= PC_RST;
      ir_q   <= REG_RST;
      mar_q  <= ADDR_W'(REG_RST_VAL);
      mdr_q  <= REG_RST;
      y_q    <= REG_RST;
      outp_q <= REG_RST;
    end else begin
      gpr_q  <= gpr_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      zhi_q  <= zhi_d;
      zlo_q  <= zlo_d;
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      mar_q  <= mar_d;
      mdr_q  <= mdr_d;
      y_q    <= y_d;
      outp_q <= outp_d;
    end
  end

  mem_handshake_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem_fsm (
    .clk           (clk),
    .rst_n         (clr),
    .mem_rd_i      (mem_rd),
    .mem_wr_i      (mem_wr),
    .mem_ack_i     (mem_ack),
    .mar_i         (mar_q),
    .mdr_i         (mdr_q),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_busy_o    (mem_busy),
    .mem_done_o    (mem_done),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mdr_ld_c      (mdr_ld_c),
    .mdr_bus_blk_c (mdr_bus_blk_c)
  );

`ifdef DATAPATH_BUS_ERR_EN
  logic bus_err_q, bus_err_d;

  // Sticky flag for any cycle with more than one bus driver
  assign bus_err_d = bus_err_q | ($countones({gpr_out, spec_out}) > 1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) bus_err_q <= 1'b0;
    else      bus_err_q <= bus_err_d;
  end

  assign bus_err = bus_err_q;
`endif

  assign bus     = bus_c;
  assign alu_a   = y_q;
  assign alu_b   = bus_c;
  assign ir      = ir_q;
  assign outport = outp_q;

endmodule

// File: doc/mem_bus_datapath.md
Name: mem_bus_datapath

Overview:
- Parametrised single-bus CPU datapath core: GPR file, HI/LO, Y, Z (hi/lo), PC, IR, MAR, MDR, outport, all sharing one internal bus.
- Replaces the fixed-latency RAM coupling with a req/ack memory handshake FSM.
- Data width and GPR count are generic.
- The ALU, select/encode logic and the control unit stay outside the block and connect through ports.

Parameters:
- DATA_W, 32: bus and register width.
- NUM_GPR, 16: number of general-purpose registers (R0..R{NUM_GPR-1}); minimum 2.
- ADDR_W, 9: memory address width; mem_addr = MAR[ADDR_W-1:0].
- PC_RESET, 0: PC value on reset.
- PC_INC, 1: amount added to PC on inc_pc.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous active-low reset
- gpr_in  in  NUM_GPR  one-hot GPR load enables from bus
- gpr_out  in  NUM_GPR  one-hot GPR bus drive enables
- ba_out  in  1  when set, R0 drives 0 onto the bus instead of its contents
- spec_in  in  9  loads {OUTP,Y,MDR,MAR,IR,PC,Z,LO,HI}, bit 0 = HI
- spec_out  in  8  drives {INP,IMM,MDR,PC,ZLO,ZHI,LO,HI}, bit 0 = HI
- inc_pc  in  1  PC <= PC + PC_INC
- imm_in  in  DATA_W  sign-extended immediate source
- inport_data  in  DATA_W  input-port source
- alu_a  out  DATA_W  = Y
- alu_b  out  DATA_W  = bus
- alu_lo, alu_hi  in  DATA_W  ALU result halves, captured into Z
- mem_rd, mem_wr  in  1  one-cycle memory operation request pulses
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  = MDR
- mem_rdata  in  DATA_W  read data
- mem_ack  in  1  memory completion
- mem_busy  out  1  FSM not IDLE
- mem_done  out  1  one-cycle completion pulse
- bus  out  DATA_W  internal bus, for observation
- ir  out  DATA_W  IR contents, feeds the external select/encode logic
- outport  out  DATA_W  output-port register

Behaviour:
- Bus (combinational):
  - Bitwise OR of all enabled sources; 0 when no source is enabled.
  - R0 contributes 0 when ba_out=1.
  - Multiple enabled sources OR together (see optional feature).
- Register capture:
  - Every register captures on the rising clk edge when its enable is set.
  - spec_in Z loads ZHI<=alu_hi and ZLO<=alu_lo in the same edge.
  - No bypass: a register loaded at edge N is visible on the bus from edge N onward.
- PC: if the PC load enable and inc_pc are both set, the load wins.
- Reset (clr=0, asynchronous):
  - All registers go to 0 except PC = PC_RESET.
  - FSM goes to IDLE; mem_req, mem_we, mem_busy and mem_done go to 0 immediately.
- Memory FSM states: IDLE, RD_WAIT, WR_WAIT, DONE.
  - IDLE: mem_rd -> RD_WAIT; else mem_wr -> WR_WAIT. If both are set, the read wins and the write is dropped.
  - RD_WAIT / WR_WAIT: mem_req=1, mem_addr is held from MAR; mem_we=1 only in WR_WAIT.
  - mem_ack=1 in RD_WAIT: MDR <= mem_rdata at that edge, go to DONE.
  - mem_ack=1 in WR_WAIT: go to DONE.
  - mem_ack in IDLE or DONE is ignored.
  - DONE: mem_done=1 for exactly one cycle, then IDLE.
  - Minimum latency: request edge -> mem_req next cycle; ack edge -> mem_done next cycle.
  - Zero-wait memory (ack in the first wait cycle) gives 3 cycles from request to IDLE.
- Hazard rules:
  - mem_rd / mem_wr while mem_busy=1 are ignored (no queueing).
  - MDR bus load in RD_WAIT is ignored in every cycle. On the ack edge mem_rdata is loaded.
  - MAR loads during a wait are accepted, but mem_addr is latched at request acceptance and stays stable until DONE.
  - mem_wdata is latched at request acceptance, so MDR changes during WR_WAIT do not alter the write.

Optional Feature:
- Macro: DATAPATH_BUS_ERR_EN.
- Defined:
  - Adds output bus_err (1 bit).
  - bus_err is set at the clk edge after any cycle with more than one bus source enabled (count over gpr_out plus spec_out).
  - bus_err is sticky until clr.
  - The bus value is still the OR.
- Undefined: no bus_err port and no checking logic.

Decomposition:
- Package datapath_pkg holds:
  - SPEC_IN_* and SPEC_OUT_* bit-index constants.
  - mem_state_t enum {IDLE, RD_WAIT, WR_WAIT, DONE}.
  - Width-generic register-reset constants.
- Sub-module mem_handshake_fsm holds the state register, address/wdata latches, mem_req/mem_we/mem_done/mem_busy, and the MDR-load-from-memory strobe.
- The top level keeps the bus OR, the register file and the special registers.

Test Plan:
- Reset: clr=0 mid-run with PC_RESET=7 -> PC=7, all other registers 0, mem_req=0 asynchronously; bus=0 with no enables.
- Bus transfer: load R3 from imm_in=0x0000_005A, then gpr_out[3]=1 with spec_in OUTP -> outport=0x5A next edge; with ba_out=1 and gpr_out[0] -> bus=0.
- ALU path: Y<=0x10, bus=0x20, alu_lo=0x30, alu_hi=0x1 -> ZLO=0x30, ZHI=0x1 after the Z load edge; PC load 0x40 with inc_pc=1 -> PC=0x40.
- Memory read, 2-cycle ack delay: MAR=0x1F3, mem_rd pulse -> mem_req=1, mem_we=0, mem_addr=0x1F3; ack with rdata 0xDEADBEEF -> MDR=0xDEADBEEF, mem_done pulses once; bus MDR load during the wait is ignored.
- Memory write: MDR=0xCAFEF00D, mem_wr=1 and mem_rd=0 -> mem_we=1, mem_wdata=0xCAFEF00D; MAR and MDR changed mid-wait -> mem_addr and mem_wdata unchanged; mem_rd during busy -> ignored, no second transaction.
- Conflict (DATAPATH_BUS_ERR_EN): gpr_out[1] and spec_out PC in the same cycle -> bus=R1|PC, bus_err=1 next edge and held until clr.
